// File: rtl/kypd_pkg.sv
// Shared constants and map helpers for the PmodKYPD 4x4 keypad scanner.
// Map bit index is {col, row}: bit 4*col + row is set when that key is pressed.
package kypd_pkg;

   localparam logic [3:0]  COL_IDLE = 4'b1111;
   // Column drive patterns, column c at bits [4c+3:4c]
   localparam logic [15:0] COL_PAT  = 16'b0111_1011_1101_1110;
   // Key code per map bit, entry i at bits [4i+3:4i]
   localparam logic [63:0] KEY_LUT  = 64'hDCBA_E963_F852_0741;

   typedef enum logic {
      ST_IDLE,
      ST_SCAN
   } state_e;

   typedef enum logic [1:0] {
      MAP_NONE,
      MAP_SINGLE,
      MAP_MULTI
   } map_kind_e;

   function automatic logic [3:0] col_drive(input logic [1:0] col);
      return COL_PAT[4*col +: 4];
   endfunction

   function automatic map_kind_e map_kind(input logic [15:0] map);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'b0000, map[i]};
      if (n == 5'd0)      return MAP_NONE;
      else if (n == 5'd1) return MAP_SINGLE;
      else                return MAP_MULTI;
   endfunction

   // Only meaningful for a one-hot map
   function automatic logic [3:0] key_lookup(input logic [15:0] map);
      logic [3:0] code;
      code = '0;
      for (int i = 0; i < 16; i++) begin
         if (map[i]) code = KEY_LUT[4*i +: 4];
      end
      return code;
   endfunction

endpackage

// File: rtl/kypd_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row inputs.
// Resets to all-ones so an idle keypad reads as "no key" from the first cycle.
module kypd_row_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] row_out
);

   logic [3:0] row_meta;

   // NOTE: sequential state uses non-blocking assignments so both stages
   // sample their inputs before either updates, giving a true two-stage chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= 4'b1111;
         row_out  <= 4'b1111;
      end else begin
         row_meta <= row_in;
         row_out  <= row_meta;
      end
   end

endmodule

// File: rtl/kypd_scan_ctrl.sv
// Column-scanning controller for the 4x4 PmodKYPD: builds full-keypad frames,
// debounces them and emits key press / release events with a hex key code.
module kypd_scan_ctrl
   import kypd_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 10,
   parameter int CNT_W          = 17
) (
   input  logic       clk,
   input  logic       sys_rst_n,
   input  logic       scan_en,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_release,
   output logic       key_held,
   output logic       multi_key
);

   localparam int               ST_W       = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [ST_W-1:0]  STABLE_MAX = ST_W'(DEBOUNCE_SCANS);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] dwell_cnt;
   logic [1:0]       col_idx;
   logic [15:0]      raw_map, raw_nxt;
   logic [15:0]      prev_map, deb_map, deb_map_d;
   logic [ST_W-1:0]  stable_cnt, stable_nxt;
   logic [3:0]       row_s;
   logic             scanning, abort, dwell_last, frame_end, deb_changed;
   map_kind_e        deb_kind;

   kypd_row_sync u_row_sync (
      .clk     (clk),
      .rst_n   (sys_rst_n),
      .row_in  (Row),
      .row_out (row_s)
   );

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      Col       = COL_IDLE;
      case (state)
         ST_IDLE: if (scan_en) state_nxt = ST_SCAN;
         ST_SCAN: begin
            Col = col_drive(col_idx);
            if (!scan_en) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign scanning   = (state == ST_SCAN) && scan_en;
   assign abort      = (state == ST_SCAN) && !scan_en;
   assign dwell_last = scanning && (dwell_cnt == DWELL_LAST);
   assign frame_end  = dwell_last && (col_idx == 2'd3);

   // Raw map with the current column's sample merged in; on column 3 this is the full frame
   always_comb begin
      raw_nxt = raw_map;
      raw_nxt[4*col_idx +: 4] = ~row_s;
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dwell_cnt <= '0;
         col_idx   <= '0;
         raw_map   <= '0;
      end else if (!scanning) begin
         dwell_cnt <= '0;
         col_idx   <= '0;
         raw_map   <= '0;
      end else if (dwell_last) begin
         dwell_cnt <= '0;
         col_idx   <= col_idx + 2'd1;
         raw_map   <= raw_nxt;
      end else begin
         dwell_cnt <= dwell_cnt + 1'b1;
      end
   end

   always_comb begin
      if (raw_nxt != prev_map)          stable_nxt = ST_W'(1);
      else if (stable_cnt == STABLE_MAX) stable_nxt = stable_cnt;
      else                              stable_nxt = stable_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         prev_map   <= '0;
         stable_cnt <= '0;
         deb_map    <= '0;
      end else if (abort) begin
         prev_map   <= '0;
         stable_cnt <= '0;
         deb_map    <= '0;
      end else if (frame_end) begin
         prev_map   <= raw_nxt;
         stable_cnt <= stable_nxt;
         if (stable_nxt == STABLE_MAX) deb_map <= raw_nxt;
      end
   end

   assign deb_kind    = map_kind(deb_map);
   assign deb_changed = (deb_map != deb_map_d);

   // Aborting also clears the delayed map so the forced drop to zero raises no release
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         deb_map_d   <= '0;
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         key_held    <= 1'b0;
         multi_key   <= 1'b0;
      end else if (abort) begin
         deb_map_d   <= '0;
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         key_held    <= 1'b0;
         multi_key   <= 1'b0;
      end else begin
         deb_map_d   <= deb_map;
         key_valid   <= deb_changed && (deb_kind == MAP_SINGLE);
         key_release <= deb_changed && (deb_kind == MAP_NONE);
         key_held    <= (deb_kind != MAP_NONE);
         multi_key   <= (deb_kind == MAP_MULTI);
         if (deb_changed && (deb_kind == MAP_SINGLE)) key_code <= key_lookup(deb_map);
      end
   end

endmodule

// File: doc/kypd_scan_ctrl.md
Name: kypd_scan_ctrl

Overview:
Scan controller for the 4x4 PmodKYPD matrix keypad. It drives one column low at a time and samples the active-low rows after a settle interval. It then debounces whole-keypad frames and emits clean key press and release events with a hex key code. It sits between the keypad pins and consumers such as the LED display logic, and runs on the 100 MHz PLL clock.

Parameters:
SCAN_DIV, 100000, clock cycles each column is held low (1 ms at 100 MHz); must be >= 4
DEBOUNCE_SCANS, 10, consecutive identical full frames required before the debounced map updates; must be >= 1
CNT_W, 17, width of the dwell counter; must satisfy 2^CNT_W >= SCAN_DIV

Ports:
clk  input  1  system clock (100 MHz)
sys_rst_n  input  1  asynchronous active-low reset
scan_en  input  1  1 = scanning active, 0 = idle
Row  input  4  keypad rows, active low, externally pulled up; Row[0] is the top row
Col  output  4  keypad columns, active low, at most one low at a time
key_code  output  4  hex code of the last single debounced key
key_valid  output  1  one-cycle pulse: new single-key press; key_code is valid that cycle
key_release  output  1  one-cycle pulse: debounced map returned to all-released
key_held  output  1  level: debounced map is non-zero
multi_key  output  1  level: debounced map has more than one key pressed

Behaviour:
- Reset (async, sys_rst_n low) values:
  - Col = 4'b1111; key_code = 0; all pulses and levels = 0.
  - Internal state: dwell counter 0, column index 0, raw/previous/debounced maps 0, stable count 0, FSM in IDLE.
- Row passes through a 2-flop synchroniser before any use.
- FSM states: IDLE and SCAN.
  - IDLE: Col = 1111. Moves to SCAN on the first cycle scan_en = 1. The dwell counter and column index start at 0.
  - SCAN: column index c (0..3) drives Col = ~(1<<c): 1110, 1101, 1011, 0111.
  - The dwell counter counts 0..SCAN_DIV-1 per column.
  - On the last dwell cycle, the synchronised Row is inverted and stored into raw map bits [4c+3:4c], then c advances.
  - c wraps 3 -> 0; that wrap is the frame end. There is no gap cycle between frames.
- Frame end processing (registered, same cycle as the column-3 sample):
  - If the new frame equals the previous frame: stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: stable count = 1 and the previous frame is replaced.
  - When stable count reaches DEBOUNCE_SCANS, the debounced map is loaded with that frame.
- Events, asserted the cycle after the debounced map changes:
  - new map one-hot and (old map zero or a different one-hot): key_valid = 1, key_code = mapped code.
  - new map zero and old map non-zero: key_release = 1.
  - new map with >= 2 bits set: multi_key = 1, no key_valid, key_code retained.
  - multi_key clears when the map becomes zero or one-hot. Returning to one-hot from multi fires key_valid.
  - key_held = (debounced map != 0), registered.
- Key map (col index, row index -> code):
  - col0: 1, 4, 7, 0
  - col1: 2, 5, 8, F
  - col2: 3, 6, 9, E
  - col3: A, B, C, D
- Debounced latency from a stable press: at most (DEBOUNCE_SCANS+1) frames plus 1 cycle, where one frame is 4*SCAN_DIV cycles.
- scan_en falling in mid-frame:
  - Next cycle: IDLE, Col = 1111, partial frame discarded.
  - Stable count, previous map and debounced map are cleared.
  - key_held and multi_key go to 0; key_code is retained; no release pulse.
- Key bounce within a frame produces a differing frame, which restarts the stability count. No event fires until DEBOUNCE_SCANS matching frames.
- Counters never overflow; the stable count saturates.

Decomposition:
- Package kypd_pkg holds:
  - the column drive pattern constants;
  - the 16-entry key code lookup constant indexed {col, row};
  - a function for one-hot and multi-bit detection on a 16-bit map.
- Sub-module kypd_row_sync: 4-bit 2-flop synchroniser with async active-low reset to 4'b1111.

Test Plan:
1. Reset: sys_rst_n = 0 with scan_en = 1. Require Col = 1111, key_code = 0, all flags 0. After release, Col steps 1110/1101/1011/0111 every SCAN_DIV cycles (run with SCAN_DIV = 4, DEBOUNCE_SCANS = 2, 16-cycle frame).
2. Clean press: hold key "5" (Row[1] low while Col = 1101) for 5 frames. Require exactly one key_valid with key_code = 5 within 3 frames + 1 cycle, and key_held = 1. On release, a single key_release pulse follows after 2 stable frames.
3. Bounce: toggle key "A" on alternate frames for 6 frames, then hold. Require no key_valid during the toggling, then one key_valid with key_code = A.
4. Multi-key: hold "1" and "D" together. Require multi_key = 1, no key_valid, key_code unchanged. Release "D". Require multi_key = 0 and key_valid with key_code = 1.
5. scan_en drop: drop scan_en mid-frame while "F" is held. Require Col = 1111 next cycle, key_held = 0, no key_release. Re-enable scan_en. Require key_valid with key_code = F after debounce.
6. Key roll: change from "3" directly to "9" without passing through zero. Require a second key_valid with key_code = 9 and no key_release in between.
